// File: rtl/instr_sequencer.sv
// Program sequencer: fetches words from a synchronous-read ROM and issues each one
// to the control unit with a one-cycle active-low run_n strobe, then waits for done.
module instr_sequencer #(
  parameter int          ADDR_W    = 5,
  parameter int          PROG_LEN  = 32,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter int          TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              done,
  input  logic [15:0]       rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       instr,
  output logic              run_n,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              timeout_err
);

  localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(PROG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD    = 3'd2,
    S_ISSUE   = 3'd3,
    S_WAIT    = 3'd4,
    S_ADVANCE = 3'd5,
    S_HALTED  = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_cnt_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [15:0]       instr_nxt;
  logic              run_n_nxt;
  logic              busy_nxt;
  logic              halted_nxt;
  logic              timeout_err_nxt;

  // The ROM is addressed directly by the program counter.
  assign rom_addr = pc;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; done in WAIT takes priority over the timeout.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (start) next_state = S_FETCH;
        else       next_state = state;
      end
      S_FETCH: next_state = S_LOAD;
      S_LOAD: begin
        if (rom_data == HALT_WORD) next_state = S_HALTED;
        else                       next_state = S_ISSUE;
      end
      S_ISSUE: next_state = S_WAIT;
      S_WAIT: begin
        if (done)                      next_state = S_ADVANCE;
        else if (wait_cnt == CNT_LAST) next_state = S_ERROR;
        else                           next_state = S_WAIT;
      end
      S_ADVANCE: begin
        if (pc == PC_LAST) next_state = S_HALTED;
        else               next_state = S_FETCH;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Output and datapath next values; status flags are decoded from the next state
  // so that every output comes straight from a flop.
  always_comb begin
    pc_nxt       = pc;
    instr_nxt    = instr;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (start) pc_nxt = {ADDR_W{1'b0}};
        else       pc_nxt = pc;
      end
      S_LOAD:  instr_nxt    = rom_data;
      S_ISSUE: wait_cnt_nxt = {CNT_W{1'b0}};
      S_WAIT: begin
        if (!done && (wait_cnt != CNT_LAST)) wait_cnt_nxt = wait_cnt + 1'b1;
        else                                 wait_cnt_nxt = wait_cnt;
      end
      S_ADVANCE: begin
        if (pc != PC_LAST) pc_nxt = pc + 1'b1;
        else               pc_nxt = pc;
      end
      default: begin
        pc_nxt = pc;
      end
    endcase
    run_n_nxt       = (next_state != S_ISSUE);
    busy_nxt        = next_state inside {S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_ADVANCE};
    halted_nxt      = (next_state == S_HALTED);
    timeout_err_nxt = (next_state == S_ERROR);
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= {ADDR_W{1'b0}};
      instr       <= 16'h0000;
      run_n       <= 1'b1;
      busy        <= 1'b0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= {CNT_W{1'b0}};
    end else begin
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      run_n       <= run_n_nxt;
      busy        <= busy_nxt;
      halted      <= halted_nxt;
      timeout_err <= timeout_err_nxt;
      wait_cnt    <= wait_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: ROM and control-unit responder models, with a
// program-level reference model predicting issued words, issue cycles and end state.
module tb_instr_sequencer;
  localparam int          TIMEOUT  = 15;
  localparam int          PROG_LEN = 32;
  localparam logic [15:0] HALT     = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        done;
  logic [15:0] rom_data = 16'h0000;
  logic [4:0]  rom_addr, pc;
  logic [15:0] instr;
  logic        run_n, busy, halted, timeout_err;

  logic        start3 = 1'b0;
  logic        done3 = 1'b0;
  logic        iss3 = 1'b0;
  logic [15:0] rom_data3 = 16'h0000;
  logic [4:0]  rom_addr3, pc3;
  logic [15:0] instr3;
  logic        run_n3, busy3, halted3, timeout_err3;

  always #5 clk = ~clk;

  instr_sequencer #(.ADDR_W(5), .PROG_LEN(PROG_LEN), .HALT_WORD(HALT), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .done(done), .rom_data(rom_data),
    .rom_addr(rom_addr), .instr(instr), .run_n(run_n), .pc(pc), .busy(busy),
    .halted(halted), .timeout_err(timeout_err));

  instr_sequencer #(.ADDR_W(5), .PROG_LEN(3), .HALT_WORD(HALT), .TIMEOUT(TIMEOUT)) u_len3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .done(done3), .rom_data(rom_data3),
    .rom_addr(rom_addr3), .instr(instr3), .run_n(run_n3), .pc(pc3), .busy(busy3),
    .halted(halted3), .timeout_err(timeout_err3));

  logic [15:0] rom [32];
  logic [15:0] rom3 [32];
  int cyc = 0;
  int ncmp = 0;
  int nfail = 0;

  always @(posedge clk) rom_data  <= rom[rom_addr];
  always @(posedge clk) rom_data3 <= rom3[rom_addr3];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue monitor: records every strobe and rejects back-to-back low cycles.
  logic [15:0] obs_w[$];
  int          obs_c[$];
  bit          prev_low = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_low = 1'b0;
    end else begin
      if (run_n === 1'b0) begin
        check("run_n_single_cycle", {31'd0, prev_low}, 32'd0);
        obs_w.push_back(instr);
        obs_c.push_back(cyc);
      end
      prev_low = (run_n === 1'b0);
    end
  end

  // Control-unit responder: done is sampled after lat_tab[k] WAIT cycles; 0 withholds it.
  int   lat_tab[32];
  int   resp_idx = 0;
  int   rem = -1;
  logic resp_done = 1'b0;
  logic noise_done = 1'b0;
  assign done = resp_done | noise_done;
  always @(negedge clk) begin
    if (!reset_n) begin
      rem = -1;
      resp_done = 1'b0;
    end else begin
      resp_done = 1'b0;
      if (run_n === 1'b0) begin
        rem = lat_tab[resp_idx % 32];
        if (rem == 0) rem = -1;
        resp_idx++;
      end else if (rem > 0) begin
        rem = rem - 1;
        if (rem == 0) begin
          resp_done = 1'b1;
          rem = -1;
        end
      end
    end
  end

  // Second instance: one-cycle WAIT responder and issue log.
  logic [15:0] q3[$];
  always @(negedge clk) begin
    done3 <= iss3;
    iss3  <= (run_n3 === 1'b0);
    if (run_n3 === 1'b0) q3.push_back(instr3);
  end

  // Reference model: walk the program by address, each issue costing lat+4 cycles.
  logic [15:0] exp_w[$];
  int          exp_c[$];
  int          exp_pc, exp_end;
  bit          exp_to;
  task automatic model();
    int a = 0;
    int t = 2;
    int i = 0;
    bit fin = 1'b0;
    exp_w.delete();
    exp_c.delete();
    exp_to = 1'b0;
    while (!fin) begin
      if (rom[a] == HALT) begin
        exp_pc = a; exp_end = t; fin = 1'b1;
      end else begin
        exp_w.push_back(rom[a]);
        exp_c.push_back(t);
        if (lat_tab[i] == 0) begin
          exp_to = 1'b1; exp_pc = a; exp_end = t + TIMEOUT + 1; fin = 1'b1;
        end else begin
          t = t + lat_tab[i] + 4;
          if (a == PROG_LEN - 1) begin
            exp_pc = a; exp_end = t - 2; fin = 1'b1;
          end else begin
            a++; i++;
          end
        end
      end
    end
  endtask

  task automatic run_prog(input string tag, input bit noise, input bit extra_start);
    int s;
    int end_c = -1;
    int n;
    model();
    obs_w.delete();
    obs_c.delete();
    resp_idx = 0;
    @(posedge clk); #1;
    if (noise) begin
      noise_done = 1'b1;
      repeat (2) @(posedge clk);
      #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s = cyc;
    @(negedge clk);
    check({tag, "_start_pc"}, {27'd0, pc}, 32'd0);
    check({tag, "_start_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_start_flags"}, {30'd0, halted, timeout_err}, 32'd0);
    if (noise || extra_start) begin
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (obs_w.size() > 0) break;
      end
      noise_done = 1'b0;
      if (extra_start) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (halted || timeout_err) begin
        end_c = cyc - s;
        break;
      end
    end
    repeat (3) @(negedge clk);
    check({tag, "_end_cycle"}, end_c, exp_end);
    check({tag, "_issue_count"}, obs_w.size(), exp_w.size());
    n = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_instr%0d", tag, i), {16'd0, obs_w[i]}, {16'd0, exp_w[i]});
      check($sformatf("%s_cycle%0d", tag, i), obs_c[i] - s, exp_c[i]);
    end
    check({tag, "_pc"}, {27'd0, pc}, exp_pc);
    check({tag, "_halted"}, {31'd0, halted}, {31'd0, ~exp_to});
    check({tag, "_timeout_err"}, {31'd0, timeout_err}, {31'd0, exp_to});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_run_n"}, {31'd0, run_n}, 32'd1);
    check({tag, "_instr"}, {16'd0, instr}, 32'd0);
    check({tag, "_pc"}, {27'd0, pc}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) begin
      rom[i] = HALT;
      lat_tab[i] = 1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_rom();
    for (int i = 0; i < 32; i++) rom3[i] = 16'(i);
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1 reset_n = 1'b1;

    // Spurious done while idle must not start anything.
    noise_done = 1'b1;
    repeat (5) @(negedge clk);
    noise_done = 1'b0;
    check("idle_done_issues", obs_w.size(), 32'd0);
    check("idle_done_busy", {31'd0, busy}, 32'd0);

    // Single MV.
    rom[0] = 16'h1203; rom[1] = HALT; lat_tab[0] = 2;
    run_prog("single_mv", 1'b0, 1'b0);

    // Mixed MV/ADD/SUB/AND with spurious done before WAIT and a start while busy.
    clear_rom();
    rom[0] = 16'h1203; rom[1] = 16'h2345; rom[2] = 16'h3456; rom[3] = 16'h4567; rom[4] = HALT;
    lat_tab[0] = 2; lat_tab[1] = 4; lat_tab[2] = 4; lat_tab[3] = 4;
    run_prog("mixed", 1'b1, 1'b1);

    // Timeout, then restart from address 0 with the error cleared.
    clear_rom();
    rom[0] = 16'h2101; rom[1] = 16'h1302; rom[2] = HALT;
    lat_tab[0] = 0;
    run_prog("timeout", 1'b0, 1'b0);
    lat_tab[0] = 3; lat_tab[1] = 2;
    run_prog("after_timeout", 1'b0, 1'b0);

    // Random programs; lat 15 is done in the last count cycle.
    for (int it = 0; it < 4; it++) begin
      int len;
      clear_rom();
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        rom[i] = 16'($urandom_range(0, 32'hFFFE));
        lat_tab[i] = $urandom_range(1, TIMEOUT);
      end
      lat_tab[0] = TIMEOUT;
      run_prog($sformatf("rand%0d", it), it[0], ~it[0]);
    end

    // Full-length program without halt word stops at the last address.
    for (int i = 0; i < 32; i++) begin
      rom[i] = 16'($urandom_range(0, 32'hFFFE));
      lat_tab[i] = $urandom_range(1, 3);
    end
    run_prog("full_len", 1'b0, 1'b0);

    // PROG_LEN = 3 boundary on the second instance.
    for (int i = 0; i < 32; i++) rom3[i] = 16'($urandom_range(0, 32'hFFFE));
    @(posedge clk); #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (halted3) break;
    end
    check("len3_halted", {31'd0, halted3}, 32'd1);
    check("len3_pc", {27'd0, pc3}, 32'd2);
    check("len3_count", q3.size(), 32'd3);
    for (int i = 0; i < 3 && i < q3.size(); i++)
      check($sformatf("len3_instr%0d", i), {16'd0, q3[i]}, {16'd0, rom3[i]});
    repeat (20) @(negedge clk);
    check("len3_no_wrap_pc", {27'd0, pc3}, 32'd2);
    check("len3_no_wrap_count", q3.size(), 32'd3);

    // Reset dropped between edges during WAIT.
    clear_rom();
    rom[0] = 16'h5A5A; lat_tab[0] = 10;
    obs_w.delete(); obs_c.delete(); resp_idx = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (obs_w.size() > 0) break;
    end
    repeat (3) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("mid_reset");
    @(posedge clk); #2 reset_n = 1'b1;
    obs_w.delete();
    repeat (30) @(negedge clk);
    check("post_reset_issues", obs_w.size(), 32'd0);
    check("post_reset_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program sequencer that feeds 16-bit instruction words to the processor control unit. It fetches words from a synchronous-read program ROM, presents each one on `instr` with a one-cycle active-low `run_n` pulse, and waits for the control unit's `done`. It then advances the program counter. It sits between the program ROM and the control unit's `run` / instruction inputs and is the initiator side of the run/done handshake.

## Interface
- `ADDR_W`, default 5: program counter / ROM address width.
- `PROG_LEN`, default 32: number of ROM words executed before automatic halt; 1..2^ADDR_W.
- `HALT_WORD`, default 16'hFFFF: instruction value that halts the sequence; it is never issued.
- `TIMEOUT`, default 15: maximum cycles spent in WAIT without `done` before the block errors; ≥ 4.
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous active-low reset.
- `start` input 1: active-high; begins execution at address 0 when not busy.
- `done` input 1: active-high completion flag from the control unit.
- `rom_data` input 16: ROM read data, valid the cycle after `rom_addr` is sampled.
- `rom_addr` output ADDR_W: combinationally equal to `pc`.
- `instr` output 16: registered instruction word driven to the control unit.
- `run_n` output 1: active-low issue strobe, exactly one cycle wide per instruction.
- `pc` output ADDR_W: address of the current instruction.
- `busy` output 1: high in FETCH, LOAD, ISSUE, WAIT and ADVANCE.
- `halted` output 1: high in HALTED.
- `timeout_err` output 1: high in ERROR.

## Operation
- Reset values: `run_n`=1, `instr`=0, `pc`=0, `busy`=0, `halted`=0, `timeout_err`=0, state IDLE, wait counter 0.
- **IDLE**: if `start` is high, go to FETCH and set `pc`=0.
- **FETCH**: one cycle; the ROM samples `rom_addr`. Next state is LOAD.
- **LOAD**: register `rom_data` into `instr`.
  - If `rom_data` == HALT_WORD, go to HALTED; `instr` still loads.
  - Otherwise go to ISSUE.
- **ISSUE**: `run_n`=0 for this cycle only. Clear the wait counter. Next state is WAIT.
- **WAIT**: `run_n`=1; `instr` is held stable.
  - If `done` is sampled high, go to ADVANCE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with `done` still low, go to ERROR.
  - `done` wins over timeout in the same cycle.
- **ADVANCE**:
  - If `pc` == PROG_LEN-1, go to HALTED and leave `pc` unchanged.
  - Otherwise `pc`=`pc`+1 and go to FETCH.
  - `pc` never wraps.
- **HALTED / ERROR**: outputs hold. `start` high returns to FETCH with `pc`=0 and clears `halted` / `timeout_err`.
- `start` is ignored while `busy`.
- `done` is ignored outside WAIT.
- `done` sampled in the ISSUE cycle itself is ignored.

## Timing
- If `start` is sampled high at edge E0:
  - FETCH runs E0→E1.
  - LOAD runs E1→E2.
  - ISSUE (`run_n`=0) runs E2→E3.
  - `instr` is valid from E2, one cycle before the control unit samples it in T0.
- Per-instruction overhead outside WAIT is 4 cycles (FETCH, LOAD, ISSUE, ADVANCE).
- A control unit that raises `done` in T1 (MV/MVT) gives a WAIT of 2 cycles. For ADD/SUB/AND, `done` comes in T3 and WAIT is 4 cycles.
- `run_n` is registered and glitch-free. It is never low for two consecutive cycles.
- Reset asserted mid-operation forces all outputs to reset values immediately, independent of the clock. After `reset_n` deasserts, the block waits in IDLE for `start`.
- Timeout: ERROR is entered TIMEOUT cycles after ISSUE with `done` low throughout.

## Test plan
- **Single MV:** ROM[0]=16'h1203, ROM[1]=HALT_WORD; pulse `start`.
  - `run_n` is low exactly 3 cycles after `start` with `instr`=16'h1203.
  - `done` is returned 2 cycles later.
  - `pc` goes 0→1, then `halted`=1; HALT_WORD is never issued (`run_n` stays 1).
- **Mixed program:** MV, ADD, SUB, AND, HALT, with the responder model giving `done` latencies of 2/4/4/4.
  - Exactly 4 `run_n` pulses, each with the matching `instr`.
  - `halted` with `pc`=4.
- **PROG_LEN boundary:** PROG_LEN=3, no halt word, `done` always returned.
  - 3 issues; `halted` with `pc`=2; no wrap to 0.
- **Timeout:** withhold `done` after the first issue.
  - `timeout_err`=1 exactly TIMEOUT=15 cycles after the ISSUE cycle; `run_n` stays 1.
  - A following `start` restarts at `pc`=0 with `timeout_err` cleared.
- **Spurious and simultaneous events:**
  - `done` asserted in IDLE, FETCH, LOAD and ISSUE is ignored.
  - `start` while `busy` is ignored.
  - `done` arriving in the TIMEOUT-1 count cycle goes to ADVANCE, not ERROR.
- **Reset mid-WAIT:** drop `reset_n` between clock edges.
  - All outputs reach reset values before the next edge.
  - After release, no `run_n` pulse occurs until `start`.
